// File: rtl/cdt_member_decoder.sv
// Membership decoder for context-dependent thinning: scores every item-memory
// entry against a thinned composite by chunked overlap popcount and streams hits.
module cdt_member_decoder #(
    parameter int HV_LENGTH = 512,
    parameter int NUM_ITEMS = 16,
    parameter int CHUNK     = 64,
    parameter int CNT_W     = $clog2(HV_LENGTH + 1),
    parameter int IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [HV_LENGTH-1:0] comp_hv_i,
    input  logic [CNT_W-1:0]     threshold_i,
    output logic                 item_rd_en_o,
    output logic [IDX_W-1:0]     item_addr_o,
    input  logic [HV_LENGTH-1:0] item_data_i,
    output logic                 hit_valid_o,
    input  logic                 hit_ready_i,
    output logic [IDX_W-1:0]     hit_idx_o,
    output logic [CNT_W-1:0]     hit_overlap_o,
    output logic [NUM_ITEMS-1:0] hit_mask_o,
    output logic                 done_o
);

    localparam int CHUNKS = HV_LENGTH / CHUNK;
    localparam int CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_COUNT, S_EVAL, S_REPORT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [HV_LENGTH-1:0] comp_q, comp_d;
    logic [HV_LENGTH-1:0] and_q, and_d;
    logic [CNT_W-1:0]     thr_q, thr_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]     item_cnt_q, item_cnt_d;
    logic [CH_W-1:0]      chunk_cnt_q, chunk_cnt_d;
    logic [NUM_ITEMS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]     hit_ovl_q, hit_ovl_d;

    logic last_item, last_chunk, is_hit;

    function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign last_item  = (item_cnt_q == IDX_W'(NUM_ITEMS - 1));
    assign last_chunk = (chunk_cnt_q == CH_W'(CHUNKS - 1));
    assign is_hit     = (acc_q >= thr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid_i) state_d = S_FETCH;
            S_FETCH:  state_d = S_LOAD;
            S_LOAD:   state_d = S_COUNT;
            S_COUNT:  if (last_chunk) state_d = S_EVAL;
            S_EVAL: begin
                if (is_hit)         state_d = S_REPORT;
                else if (last_item) state_d = S_DONE;
                else                state_d = S_FETCH;
            end
            S_REPORT: if (hit_ready_i) state_d = last_item ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o   = (state_q == S_IDLE);
        item_rd_en_o = (state_q == S_FETCH);
        hit_valid_o  = (state_q == S_REPORT);
        done_o       = (state_q == S_DONE);
    end

    assign item_addr_o   = item_cnt_q;
    assign hit_idx_o     = hit_idx_q;
    assign hit_overlap_o = hit_ovl_q;
    assign hit_mask_o    = mask_q;

    always_comb begin
        comp_d      = comp_q;
        and_d       = and_q;
        thr_d       = thr_q;
        acc_d       = acc_q;
        item_cnt_d  = item_cnt_q;
        chunk_cnt_d = chunk_cnt_q;
        mask_d      = mask_q;
        hit_idx_d   = hit_idx_q;
        hit_ovl_d   = hit_ovl_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    comp_d     = comp_hv_i;
                    thr_d      = threshold_i;
                    item_cnt_d = '0;
                    mask_d     = '0;
                end
            end
            S_LOAD: begin
                and_d       = item_data_i & comp_q;
                acc_d       = '0;
                chunk_cnt_d = '0;
            end
            // AND register is shifted down one chunk per cycle, so the low
            // CHUNK bits always hold the chunk selected by chunk_cnt.
            S_COUNT: begin
                acc_d       = acc_q + popcount(and_q[CHUNK-1:0]);
                and_d       = and_q >> CHUNK;
                chunk_cnt_d = chunk_cnt_q + CH_W'(1);
            end
            S_EVAL: begin
                if (is_hit) begin
                    mask_d[item_cnt_q] = 1'b1;
                    hit_idx_d          = item_cnt_q;
                    hit_ovl_d          = acc_q;
                end else if (!last_item) begin
                    item_cnt_d = item_cnt_q + IDX_W'(1);
                end
            end
            S_REPORT: begin
                if (hit_ready_i && !last_item) item_cnt_d = item_cnt_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            comp_q      <= '0;
            and_q       <= '0;
            thr_q       <= '0;
            acc_q       <= '0;
            item_cnt_q  <= '0;
            chunk_cnt_q <= '0;
            mask_q      <= '0;
            hit_idx_q   <= '0;
            hit_ovl_q   <= '0;
        end else begin
            comp_q      <= comp_d;
            and_q       <= and_d;
            thr_q       <= thr_d;
            acc_q       <= acc_d;
            item_cnt_q  <= item_cnt_d;
            chunk_cnt_q <= chunk_cnt_d;
            mask_q      <= mask_d;
            hit_idx_q   <= hit_idx_d;
            hit_ovl_q   <= hit_ovl_d;
        end
    end

endmodule

// File: tb/tb_cdt_member_decoder.sv
// Directed bench for cdt_member_decoder: 4 items of 512 bits, 64-bit chunks
// (11 cycles per item without hits). Cycle n = n-th cycle after the accept edge.
module tb_cdt_member_decoder;

    localparam int HV = 512;
    localparam int NI = 4;
    localparam int CK = 64;
    localparam int CW = 10;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          hit_ready = 1'b1;
    logic [HV-1:0] comp = '0;
    logic [CW-1:0] thr = '0;
    logic [HV-1:0] item_data = '0;
    logic [HV-1:0] mem [NI];

    logic          in_ready, item_rd_en, hit_valid, done;
    logic [IW-1:0] item_addr, hit_idx;
    logic [CW-1:0] hit_ovl;
    logic [NI-1:0] hit_mask;

    int total = 0;
    int passed = 0;
    int nhits, done_at, stable_cnt, pulses;
    int hidx [8];
    int hovl [8];
    logic [NI-1:0] mask_done;
    logic [HV-1:0] c3, c5, ones;

    cdt_member_decoder #(.HV_LENGTH(HV), .NUM_ITEMS(NI), .CHUNK(CK)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .comp_hv_i(comp), .threshold_i(thr),
        .item_rd_en_o(item_rd_en), .item_addr_o(item_addr), .item_data_i(item_data),
        .hit_valid_o(hit_valid), .hit_ready_i(hit_ready),
        .hit_idx_o(hit_idx), .hit_overlap_o(hit_ovl),
        .hit_mask_o(hit_mask), .done_o(done)
    );

    always #5 clk = ~clk;

    // Item memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (item_rd_en) item_data <= mem[item_addr];
    end

    function automatic logic [HV-1:0] bits(input int lo, input int n);
        logic [HV-1:0] v;
        v = '0;
        for (int i = lo; i < lo + n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic start_q(input logic [HV-1:0] c, input logic [CW-1:0] t, input bit hold);
        @(negedge clk);
        comp = c;
        thr = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Watches one query until done_o; the first hit is stalled for 'stall' cycles.
    task automatic mon(input int stall);
        int stall_left;
        logic [IW-1:0] s_idx;
        logic [CW-1:0] s_ovl;
        nhits = 0;
        done_at = -1;
        stable_cnt = 0;
        stall_left = stall;
        mask_done = 'x;
        s_idx = '0;
        s_ovl = '0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (hit_valid && stall_left > 0) begin
                hit_ready = 1'b0;
                if (stall_left == stall) begin
                    s_idx = hit_idx;
                    s_ovl = hit_ovl;
                end
                if (hit_idx == s_idx && hit_ovl == s_ovl) stable_cnt++;
                stall_left--;
            end else begin
                hit_ready = 1'b1;
            end
            if (hit_valid && hit_ready && nhits < 8) begin
                hidx[nhits] = int'(hit_idx);
                hovl[nhits] = int'(hit_ovl);
                nhits++;
            end
            if (done) begin
                done_at = n;
                mask_done = hit_mask;
                break;
            end
        end
        hit_ready = 1'b1;
    endtask

    initial begin
        c3   = bits(0, 20) | bits(128, 20);
        c5   = bits(64, 16);
        ones = '1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_mask", hit_mask, 0);
        chk("rst_rd_en", item_rd_en, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_hit_ovl", hit_ovl, 0);
        rst = 1'b0;

        // No members: all-zero composite, threshold 1
        for (int i = 0; i < NI; i++) mem[i] = bits(i * 32, 32);
        start_q('0, 10'd1, 1'b0);
        mon(0);
        chk("none_nhits", nhits, 0);
        chk("none_mask", mask_done, 0);
        chk("none_done_at", done_at, 45);

        // Membership decode: items 0 and 2 present with 20-bit overlap
        for (int i = 0; i < NI; i++) mem[i] = bits(i * 64, 40);
        start_q(c3, 10'd16, 1'b0);
        mon(0);
        chk("dec_nhits", nhits, 2);
        chk("dec_idx0", hidx[0], 0);
        chk("dec_ovl0", hovl[0], 20);
        chk("dec_idx1", hidx[1], 2);
        chk("dec_ovl1", hovl[1], 20);
        chk("dec_mask", mask_done, 4'b0101);
        chk("dec_done_at", done_at, 47);

        // Backpressure: first hit stalled for 10 cycles
        start_q(c3, 10'd16, 1'b0);
        mon(10);
        chk("bp_stable_cycles", stable_cnt, 10);
        chk("bp_nhits", nhits, 2);
        chk("bp_idx0", hidx[0], 0);
        chk("bp_ovl0", hovl[0], 20);
        chk("bp_mask", mask_done, 4'b0101);
        chk("bp_done_at", done_at, 57);

        // Threshold boundaries: item 1 overlap exactly 16
        start_q(c5, 10'd16, 1'b0);
        mon(0);
        chk("thr16_mask", mask_done, 4'b0010);
        chk("thr16_ovl", hovl[0], 16);
        chk("thr16_done_at", done_at, 46);
        start_q(c5, 10'd17, 1'b0);
        mon(0);
        chk("thr17_nhits", nhits, 0);
        chk("thr17_mask", mask_done, 4'b0000);
        chk("thr17_done_at", done_at, 45);
        start_q(c5, 10'd0, 1'b0);
        mon(0);
        chk("thr0_mask", mask_done, 4'b1111);
        chk("thr0_nhits", nhits, 4);
        chk("thr0_done_at", done_at, 49);
        mem[3] = ones;
        start_q(ones, 10'd512, 1'b0);
        mon(0);
        chk("full_nhits", nhits, 1);
        chk("full_idx", hidx[0], 3);
        chk("full_ovl", hovl[0], 512);
        chk("full_mask", mask_done, 4'b1000);
        mem[3] = bits(192, 40);

        // Reset mid-COUNT of item 2 (item 0 hit adds one REPORT cycle)
        start_q(c3, 10'd16, 1'b0);
        repeat (28) @(negedge clk);
        chk("abort_mask_before", hit_mask, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_hit_valid", hit_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_mask", hit_mask, 0);
        rst = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || hit_valid) pulses++;
        end
        chk("abort_no_done", pulses, 0);

        // Back-to-back: in_valid held, second query accepted the cycle after done
        start_q(c3, 10'd16, 1'b1);
        comp = c5;
        thr = 10'd16;
        mon(0);
        chk("b2b_q1_mask", mask_done, 4'b0101);
        chk("b2b_q1_done_at", done_at, 47);
        @(negedge clk);
        chk("b2b_idle_ready", in_ready, 1);
        chk("b2b_mask_held", hit_mask, 4'b0101);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accepted", in_ready, 0);
        chk("b2b_mask_cleared", hit_mask, 0);
        mon(0);
        chk("b2b_q2_mask", mask_done, 4'b0010);
        chk("b2b_q2_idx", hidx[0], 1);
        // Cycle 1 of query 2 was consumed above: 46 cycles after accept.
        chk("b2b_q2_done_at", done_at, 45);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdt_member_decoder.md
Name: cdt_member_decoder

Overview:
- Decoder-side counterpart to context-dependent thinning.
- Takes a thinned composite hypervector and tests every item stored in the external item memory for membership.
- Membership is decided by overlap count, popcount(item & composite), compared against a programmable threshold.
- Sits after the CDT/accumulator path. Streams hit indices to the controller and leaves a final hit mask for it.

Parameters:
HV_LENGTH, 512, hypervector width in bits
NUM_ITEMS, 16, item memory depth (items tested per query)
CHUNK, 64, bits popcounted per cycle; HV_LENGTH must be a multiple of CHUNK
CNT_W, $clog2(HV_LENGTH+1), overlap/threshold width (derived)
IDX_W, $clog2(NUM_ITEMS) (min 1), item index width (derived)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
in_valid_i  input  1  query valid
in_ready_o  output  1  decoder idle, query accepted
comp_hv_i  input  HV_LENGTH  thinned composite HV
threshold_i  input  CNT_W  minimum overlap for membership
item_rd_en_o  output  1  item memory read strobe
item_addr_o  output  IDX_W  item memory address
item_data_i  input  HV_LENGTH  item memory data, valid one cycle after item_rd_en_o
hit_valid_o  output  1  hit report valid
hit_ready_i  input  1  hit report accepted
hit_idx_o  output  IDX_W  index of member item
hit_overlap_o  output  CNT_W  overlap count of that item
hit_mask_o  output  NUM_ITEMS  bit i set if item i was a member; valid when done_o is asserted
done_o  output  1  one-cycle pulse, query complete

Behaviour:
- Reset: state IDLE. All outputs 0 except in_ready_o=1. Internal registers cleared: composite, threshold, item counter, chunk counter, accumulator, AND register, mask.
- Reset takes priority in any state. It aborts an in-flight query silently: no done_o, pending hit dropped.
- IDLE: in_ready_o=1. On in_valid_i&in_ready_o, latch comp_hv_i and threshold_i, set item_cnt=0, clear mask, go to FETCH. In all other states in_ready_o=0 and new queries are not accepted.
- FETCH (1 cycle): item_rd_en_o=1, item_addr_o=item_cnt. Go to LOAD.
- LOAD (1 cycle): and_reg <= item_data_i & comp_reg. acc <= 0. chunk_cnt <= 0. Go to COUNT.
- COUNT (HV_LENGTH/CHUNK cycles): acc += popcount(and_reg[chunk_cnt*CHUNK +: CHUNK]). Go to EVAL after the last chunk.
- EVAL (1 cycle): hit = (acc >= threshold_i latched value), unsigned compare.
  - On hit: set mask[item_cnt], load hit_idx_o=item_cnt and hit_overlap_o=acc, go to REPORT.
  - Otherwise go to NEXT logic.
- REPORT: hit_valid_o=1, with hit_idx_o and hit_overlap_o held stable until hit_ready_i. The handshake completes in the cycle hit_valid_o&hit_ready_i. hit_valid_o drops the next cycle. Minimum 1 cycle in REPORT; unbounded stall allowed.
- NEXT logic, taken from EVAL (no hit) or from REPORT (on handshake):
  - If item_cnt==NUM_ITEMS-1, go to DONE.
  - Otherwise item_cnt++ and go to FETCH.
- DONE (1 cycle): done_o=1. hit_mask_o holds the query's result from DONE until the next accepted query, where it is cleared. Return to IDLE; in_ready_o=1 the following cycle.
- Latency per item: CHUNKS+3 cycles with no hit (CHUNKS=HV_LENGTH/CHUNK). A hit adds the REPORT cycles.
- Query latency with no hits: done_o is high exactly NUM_ITEMS*(CHUNKS+3)+1 cycles after the accept edge.
- Width rules:
  - acc is CNT_W bits and cannot overflow, since max overlap is HV_LENGTH.
  - threshold_i=0 makes every item a hit, including all-zero items.
  - An all-zero composite gives overlap 0 for all items.
- hit_ready_i asserted outside REPORT is ignored.
- item_rd_en_o is asserted only in FETCH.

Test Plan:
Parameters for all scenarios: HV_LENGTH=512, NUM_ITEMS=4, CHUNK=64 (CHUNKS=8, 11 cycles per item).
1. Reset behaviour: assert rst_i mid-COUNT of item 2 -> next cycle in_ready_o=1, hit_valid_o=0, done_o=0, hit_mask_o=0. No done_o pulse follows.
2. No members: items = four disjoint 32-bit patterns, composite=0, threshold=1 -> no hit_valid_o, hit_mask_o=4'b0000, done_o exactly 45 cycles after accept.
3. Membership decode:
   - Items i = bits [i*64 +: 40] set. Composite = items 0 and 2 ORed, then thinned to 20 bits each. Threshold=16.
   - hit_ready_i tied 1 -> hits reported in order, idx 0 overlap 20 then idx 2 overlap 20, mask=4'b0101.
   - done_o at 47 cycles after accept.
4. Backpressure: scenario 3 with hit_ready_i held low for 10 cycles on the first hit -> hit_valid_o, idx 0 and overlap 20 are stable all 10 cycles, exactly one report per hit, done_o 10 cycles later.
5. Threshold boundaries, item 1 overlap exactly 16:
   - threshold=16 -> hit.
   - threshold=17 -> no hit.
   - threshold=0 -> mask=4'b1111.
   - All-ones composite and item -> overlap 512 reported without wrap.
6. Back-to-back queries: in_valid_i held high with a second query -> accepted in the cycle after done_o. Mask clears on accept. The second query's mask is independent of the first.
